// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall arbitration, two-step exception redirect, stall counter and stall watchdog
module pipe_ctrl #(
    parameter logic [31:0] EXC_VECTOR  = 32'h00000020,
    parameter logic [31:0] ERET_TYPE   = 32'h0000000e,
    parameter int unsigned STALL_LIMIT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_from_id,
    input  logic        stallreq_from_ex,
    input  logic        stallreq_from_mem,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] cp0_epc_i,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic [31:0] stall_cycles,
    output logic        stall_timeout
);
    typedef enum logic {RUN, FLUSH} state_t;

    localparam logic [15:0] LIMIT = 16'(STALL_LIMIT);

    state_t      state, state_nxt;
    logic [31:0] exc_q;
    logic [15:0] wd_cnt, wd_nxt;
    logic        exc, req;

    assign exc = excepttype_i != 32'd0;
    assign req = stallreq_from_id | stallreq_from_ex | stallreq_from_mem;

    // next state and pipeline control; the exception's RUN cycle doubles as the freeze cycle
    always_comb begin
        state_nxt = RUN;
        stall     = 6'b000000;
        flush     = 1'b0;
        new_pc    = 32'd0;
        if (state == FLUSH) begin
            flush  = 1'b1;
            new_pc = (exc_q == ERET_TYPE) ? cp0_epc_i : EXC_VECTOR;
        end else if (exc) begin
            stall     = 6'b111111;
            state_nxt = FLUSH;
        end else begin
            stall = stallreq_from_mem ? 6'b011111 :
                    stallreq_from_ex  ? 6'b001111 :
                    stallreq_from_id  ? 6'b000111 : 6'b000000;
        end
        if (!rst) stall = 6'b000000;
    end

    // watchdog: counts consecutive requested stalls, holds across a freeze, saturates at the limit
    always_comb begin
        wd_nxt = 16'd0;
        if (state == RUN && req)
            wd_nxt = (exc || wd_cnt == LIMIT) ? wd_cnt : wd_cnt + 16'd1;
    end

    // state, latched exception code, counters and sticky timeout flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= RUN;
            exc_q         <= 32'd0;
            wd_cnt        <= 16'd0;
            stall_cycles  <= 32'd0;
            stall_timeout <= 1'b0;
        end else begin
            state  <= state_nxt;
            wd_cnt <= wd_nxt;
            if (state == RUN && exc) exc_q <= excepttype_i;
            if (wd_nxt == LIMIT) stall_timeout <= 1'b1;
            if (stall[0] && stall_cycles != 32'hFFFFFFFF) stall_cycles <= stall_cycles + 32'd1;
        end
    end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: scoreboard bench for pipe_ctrl with a short watchdog limit
module tb_pipe_ctrl;
    typedef struct {
        logic        id, ex, mem;
        logic [31:0] exc, epc;
        logic [5:0]  st;
        logic        fl;
        logic [31:0] pc;
        logic        to;
    } vec_t;

    typedef struct {
        logic [5:0]  st;
        logic        fl;
        logic [31:0] pc;
        logic        to;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_from_id, stallreq_from_ex, stallreq_from_mem;
    logic [31:0] excepttype_i, cp0_epc_i;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic [31:0] stall_cycles;
    logic        stall_timeout;

    int   checks = 0;
    int   errors = 0;
    int   exp_sc = 0;
    exp_t exp_q[$];

    pipe_ctrl #(.EXC_VECTOR(32'h00000020), .ERET_TYPE(32'h0000000e), .STALL_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .stallreq_from_id(stallreq_from_id), .stallreq_from_ex(stallreq_from_ex),
        .stallreq_from_mem(stallreq_from_mem),
        .excepttype_i(excepttype_i), .cp0_epc_i(cp0_epc_i),
        .stall(stall), .flush(flush), .new_pc(new_pc),
        .stall_cycles(stall_cycles), .stall_timeout(stall_timeout)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic id, ex, mem, input logic [31:0] exc, epc,
                                input logic [5:0] st, input logic fl, input logic [31:0] pc,
                                input logic to);
        vec_t v;
        v.id = id; v.ex = ex; v.mem = mem; v.exc = exc; v.epc = epc;
        v.st = st; v.fl = fl; v.pc = pc; v.to = to;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        exp_t e;
        stallreq_from_id  = v.id;
        stallreq_from_ex  = v.ex;
        stallreq_from_mem = v.mem;
        excepttype_i      = v.exc;
        cp0_epc_i         = v.epc;
        e.st = v.st; e.fl = v.fl; e.pc = v.pc; e.to = v.to;
        exp_q.push_back(e);
    endtask

    task automatic test_reset;
        stallreq_from_mem = 1'b1;
        #1;
        checks++;
        if ({stall, flush, new_pc, stall_cycles, stall_timeout} !== 72'd0) begin
            errors++;
            $display("FAIL reset: got stall=%b flush=%b new_pc=%h cycles=%0d to=%b, expected all zero",
                     stall, flush, new_pc, stall_cycles, stall_timeout);
        end
        @(negedge clk) rst = 1'b1;
        stallreq_from_mem = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (flush !== 1'b0 || stall !== 6'b000000) begin
            errors++;
            $display("FAIL reset_release: got stall=%b flush=%b, expected 000000 0", stall, flush);
        end
    endtask

    task automatic test_priority;
        vec_t rows[4];
        exp_t e;
        rows[0] = mk(1, 0, 0, 0, 0, 6'b000111, 0, 0, 0);
        rows[1] = mk(1, 1, 0, 0, 0, 6'b001111, 0, 0, 0);
        rows[2] = mk(1, 1, 1, 0, 0, 6'b011111, 0, 0, 0);
        rows[3] = mk(0, 0, 0, 0, 0, 6'b000000, 0, 0, 0);
        foreach (rows[i]) begin
            apply(rows[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({stall, flush, new_pc, stall_timeout} !== {e.st, e.fl, e.pc, e.to}) begin
                errors++;
                $display("FAIL priority[%0d]: got stall=%b flush=%b new_pc=%h to=%b, expected stall=%b flush=%b new_pc=%h to=%b",
                         i, stall, flush, new_pc, stall_timeout, e.st, e.fl, e.pc, e.to);
            end
            @(posedge clk); #1;
            if (rows[i].st[0]) exp_sc++;
        end
        checks++;
        if (stall_cycles !== 32'(exp_sc)) begin
            errors++;
            $display("FAIL priority_cycles: got %0d expected %0d", stall_cycles, exp_sc);
        end
    endtask

    task automatic test_syscall;
        vec_t rows[3];
        exp_t e;
        rows[0] = mk(0, 1, 0, 32'h8, 0, 6'b111111, 0, 32'h0,  0);
        rows[1] = mk(1, 1, 1, 32'h0, 0, 6'b000000, 1, 32'h20, 0);
        rows[2] = mk(0, 0, 0, 32'h0, 0, 6'b000000, 0, 32'h0,  0);
        foreach (rows[i]) begin
            apply(rows[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({stall, flush, new_pc, stall_timeout} !== {e.st, e.fl, e.pc, e.to}) begin
                errors++;
                $display("FAIL syscall[%0d]: got stall=%b flush=%b new_pc=%h to=%b, expected stall=%b flush=%b new_pc=%h to=%b",
                         i, stall, flush, new_pc, stall_timeout, e.st, e.fl, e.pc, e.to);
            end
            @(posedge clk); #1;
            if (rows[i].st[0]) exp_sc++;
        end
        checks++;
        if (stall_cycles !== 32'(exp_sc)) begin
            errors++;
            $display("FAIL syscall_cycles: got %0d expected %0d", stall_cycles, exp_sc);
        end
    endtask

    task automatic test_eret;
        vec_t rows[3];
        exp_t e;
        rows[0] = mk(0, 0, 0, 32'he, 32'h100,      6'b111111, 0, 32'h0,        0);
        rows[1] = mk(0, 0, 0, 32'h0, 32'hBFC00400, 6'b000000, 1, 32'hBFC00400, 0);
        rows[2] = mk(0, 0, 0, 32'h0, 32'hBFC00400, 6'b000000, 0, 32'h0,        0);
        foreach (rows[i]) begin
            apply(rows[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({stall, flush, new_pc, stall_timeout} !== {e.st, e.fl, e.pc, e.to}) begin
                errors++;
                $display("FAIL eret[%0d]: got stall=%b flush=%b new_pc=%h to=%b, expected stall=%b flush=%b new_pc=%h to=%b",
                         i, stall, flush, new_pc, stall_timeout, e.st, e.fl, e.pc, e.to);
            end
            @(posedge clk); #1;
            if (rows[i].st[0]) exp_sc++;
        end
    endtask

    task automatic test_back_to_back;
        vec_t rows[5];
        exp_t e;
        rows[0] = mk(0, 0, 0, 32'h8, 32'h300, 6'b111111, 0, 32'h0,   0);
        rows[1] = mk(0, 0, 0, 32'h8, 32'h300, 6'b000000, 1, 32'h20,  0);
        rows[2] = mk(0, 0, 0, 32'he, 32'h300, 6'b111111, 0, 32'h0,   0);
        rows[3] = mk(0, 0, 0, 32'h0, 32'h300, 6'b000000, 1, 32'h300, 0);
        rows[4] = mk(0, 0, 0, 32'h0, 32'h300, 6'b000000, 0, 32'h0,   0);
        foreach (rows[i]) begin
            apply(rows[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({stall, flush, new_pc, stall_timeout} !== {e.st, e.fl, e.pc, e.to}) begin
                errors++;
                $display("FAIL back_to_back[%0d]: got stall=%b flush=%b new_pc=%h to=%b, expected stall=%b flush=%b new_pc=%h to=%b",
                         i, stall, flush, new_pc, stall_timeout, e.st, e.fl, e.pc, e.to);
            end
            @(posedge clk); #1;
            if (rows[i].st[0]) exp_sc++;
        end
        checks++;
        if (stall_cycles !== 32'(exp_sc)) begin
            errors++;
            $display("FAIL b2b_cycles: got %0d expected %0d", stall_cycles, exp_sc);
        end
    endtask

    task automatic test_watchdog;
        vec_t rows[9];
        exp_t e;
        rows[0] = mk(0, 1, 0, 32'h0, 0, 6'b001111, 0, 32'h0,  0);
        rows[1] = mk(0, 1, 0, 32'h0, 0, 6'b001111, 0, 32'h0,  0);
        rows[2] = mk(0, 1, 0, 32'h0, 0, 6'b001111, 0, 32'h0,  0);
        rows[3] = mk(0, 1, 0, 32'h0, 0, 6'b001111, 0, 32'h0,  0);
        rows[4] = mk(0, 0, 0, 32'h0, 0, 6'b000000, 0, 32'h0,  1);
        rows[5] = mk(0, 0, 0, 32'h0, 0, 6'b000000, 0, 32'h0,  1);
        rows[6] = mk(0, 0, 0, 32'h8, 0, 6'b111111, 0, 32'h0,  1);
        rows[7] = mk(0, 0, 0, 32'h0, 0, 6'b000000, 1, 32'h20, 1);
        rows[8] = mk(0, 0, 0, 32'h0, 0, 6'b000000, 0, 32'h0,  1);
        foreach (rows[i]) begin
            apply(rows[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({stall, flush, new_pc, stall_timeout} !== {e.st, e.fl, e.pc, e.to}) begin
                errors++;
                $display("FAIL watchdog[%0d]: got stall=%b flush=%b new_pc=%h to=%b, expected stall=%b flush=%b new_pc=%h to=%b",
                         i, stall, flush, new_pc, stall_timeout, e.st, e.fl, e.pc, e.to);
            end
            @(posedge clk); #1;
            if (rows[i].st[0]) exp_sc++;
        end
    endtask

    task automatic test_async_reset;
        vec_t rows[2];
        exp_t e;
        apply(mk(0, 0, 0, 32'h8, 0, 6'b111111, 0, 32'h0, 1));
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if ({stall, flush, new_pc, stall_timeout} !== {e.st, e.fl, e.pc, e.to}) begin
            errors++;
            $display("FAIL async_freeze: got stall=%b flush=%b new_pc=%h to=%b, expected stall=%b flush=%b new_pc=%h to=%b",
                     stall, flush, new_pc, stall_timeout, e.st, e.fl, e.pc, e.to);
        end
        @(posedge clk); #1;
        excepttype_i     = 32'h0;
        stallreq_from_id = 1'b1;
        checks++;
        if (flush !== 1'b1 || new_pc !== 32'h20) begin
            errors++;
            $display("FAIL async_in_flush: got flush=%b new_pc=%h, expected 1 00000020", flush, new_pc);
        end
        #2 rst = 1'b0;
        #1;
        exp_sc = 0;
        checks++;
        if ({stall, flush, new_pc, stall_cycles, stall_timeout} !== 72'd0) begin
            errors++;
            $display("FAIL async_reset: got stall=%b flush=%b new_pc=%h cycles=%0d to=%b, expected all zero",
                     stall, flush, new_pc, stall_cycles, stall_timeout);
        end
        @(posedge clk); #1;
        checks++;
        if (flush !== 1'b0 || stall_cycles !== 32'd0) begin
            errors++;
            $display("FAIL async_hold: got flush=%b cycles=%0d, expected 0 0", flush, stall_cycles);
        end
        @(negedge clk) rst = 1'b1;
        stallreq_from_id = 1'b0;
        @(posedge clk); #1;
        rows[0] = mk(0, 0, 0, 32'h0, 0, 6'b000000, 0, 32'h0, 0);
        rows[1] = mk(1, 0, 0, 32'h0, 0, 6'b000111, 0, 32'h0, 0);
        foreach (rows[i]) begin
            apply(rows[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({stall, flush, new_pc, stall_timeout} !== {e.st, e.fl, e.pc, e.to}) begin
                errors++;
                $display("FAIL post_reset[%0d]: got stall=%b flush=%b new_pc=%h to=%b, expected stall=%b flush=%b new_pc=%h to=%b",
                         i, stall, flush, new_pc, stall_timeout, e.st, e.fl, e.pc, e.to);
            end
            @(posedge clk); #1;
            if (rows[i].st[0]) exp_sc++;
        end
        checks++;
        if (stall_cycles !== 32'(exp_sc)) begin
            errors++;
            $display("FAIL post_reset_cycles: got %0d expected %0d", stall_cycles, exp_sc);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst = 1'b0;
        stallreq_from_id = 1'b0;
        stallreq_from_ex = 1'b0;
        stallreq_from_mem = 1'b0;
        excepttype_i = 32'h0;
        cp0_epc_i = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        test_reset;
        test_priority;
        test_syscall;
        test_eret;
        test_back_to_back;
        test_watchdog;
        test_async_reset;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Pipeline control unit that drives the per-stage stall vector and the flush/new_pc pair consumed by the pc_reg, if_id, id_ex, ex_mem and mem_wb pipeline registers.
- Arbitrates stall requests from the ID, EX and MEM stages.
- Handles exceptions reported from MEM with a two-step sequence: one freeze cycle, then one flush cycle. The freeze cycle lets CP0 commit EPC/Cause before the redirect target is read.
- Keeps a saturating stall-cycle counter and a sticky stall watchdog for debug.

Parameters:
EXC_VECTOR, 32'h00000020, redirect address for every exception except eret
ERET_TYPE, 32'h0000000e, excepttype code that selects cp0_epc_i as the target
STALL_LIMIT, 64, consecutive stall-request cycles (legal range 1..65535) before stall_timeout sets

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset
stallreq_from_id  input  1  ID stage needs to hold (load-use etc.)
stallreq_from_ex  input  1  EX stage multi-cycle op (div/madd)
stallreq_from_mem  input  1  MEM stage bus wait
excepttype_i  input  32  exception type from MEM; 0 means no exception
cp0_epc_i  input  32  current EPC from CP0 (already forwarded)
stall  output  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = Stop
flush  output  1  squash all pipeline registers, load new_pc
new_pc  output  32  redirect address, valid only while flush=1
stall_cycles  output  32  count of cycles with stall[0]=1, saturating
stall_timeout  output  1  sticky watchdog flag

Behaviour:
- Reset (rst=0, asynchronous):
  - state=RUN; exc_q, watchdog counter and stall_cycles cleared.
  - stall=6'b000000, flush=0, new_pc=0, stall_timeout=0.
  - Reset asserted mid-FREEZE or mid-FLUSH aborts the sequence; no flush pulse follows reset release.
- States: RUN, FLUSH. The freeze cycle is the RUN cycle in which an exception is detected.
- RUN:
  - If excepttype_i != 0: stall=6'b111111 (combinational, same cycle); excepttype_i is latched into exc_q; next state is FLUSH. The exception overrides every stall request.
  - Else stall is the highest-priority active request:
    - mem: 6'b011111
    - ex: 6'b001111
    - id: 6'b000111
    - none: 6'b000000
  - flush=0, new_pc=0.
- FLUSH (exactly 1 cycle, Moore):
  - flush=1, stall=6'b000000.
  - new_pc = cp0_epc_i (sampled combinationally this cycle) if exc_q==ERET_TYPE, else EXC_VECTOR.
  - excepttype_i and all stall requests are ignored; the instructions raising them are squashed.
  - Next state is RUN unconditionally.
- Back-to-back exceptions: an exception seen in the first RUN cycle after FLUSH starts a new freeze normally. The minimum spacing between flush pulses is 2 cycles.
- stall_cycles: increments by 1 on each edge where stall[0]=1, including the freeze cycle. It holds at 32'hFFFFFFFF and never wraps.
- Watchdog counter (16 bit):
  - Increments on each RUN cycle with any stallreq active and no exception.
  - Clears to 0 on any cycle with no request, and in FLUSH.
  - stall_timeout sets on the edge where the counter reaches STALL_LIMIT. It stays 1 until reset; the counter saturates at STALL_LIMIT.
- No combinational path exists from excepttype_i to flush; flush depends only on state. stall depends combinationally on the requests, excepttype_i and state.

Test Plan:
1. Stall priority: in RUN, assert id only -> stall=000111; id+ex -> 001111; id+ex+mem -> 011111; drop all -> 000000 in the same cycle. stall_cycles increases by 3 over those 3 stalled cycles.
2. Syscall: excepttype_i=32'h8 at cycle T with stallreq_from_ex=1.
   - T: stall=111111, flush=0.
   - T+1: flush=1, new_pc=32'h00000020, stall=000000.
   - T+2: flush=0.
3. eret: excepttype_i=32'he at T; cp0_epc_i changes from 32'h100 to 32'hBFC00400 at T+1 -> new_pc=32'hBFC00400 at T+1.
4. Back-to-back: exceptions at T and T+1 (the second is ignored) and again at T+2 -> flush pulses at T+1 and T+3 only.
5. Watchdog: STALL_LIMIT=4, hold stallreq_from_ex for 4 cycles -> stall_timeout=1 after the 4th edge. Stays 1 after the request drops, through a later flush; cleared only by rst=0.
6. Async reset: drop rst mid-FLUSH, between clock edges -> flush, stall, new_pc, stall_cycles go to 0 immediately. After release, the first cycle is RUN with no flush.
